microprocessor_core: RTL

//  Parametrised multi-cycle successor of the 8-bit four-register teaching CPU.

---
 rtl/microprocessor_core_if.sv | 25 ++
 rtl/microprocessor_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/microprocessor_core_if.sv
// rtl/microprocessor_core_if.sv - instruction fetch bus between core and instruction store
interface microprocessor_core_if #(
  parameter int PC_W = 8
);
  logic [7:0]      instruction;
  logic            instr_valid;
  logic            instr_req;
  logic [PC_W-1:0] instruction_address;

  // core side: issues requests and the fetch address
  modport master (
    input  instruction,
    input  instr_valid,
    output instr_req,
    output instruction_address
  );

  // instruction store side: answers with the instruction word
  modport slave (
    output instruction,
    output instr_valid,
    input  instr_req,
    input  instruction_address
  );
endinterface

// File: rtl/microprocessor_core.sv
// rtl/microprocessor_core.sv - multi-cycle four-register CPU with internal data memory
module microprocessor_core #(
  parameter int DATA_W    = 8,
  parameter int PC_W      = 8,
  parameter int MEM_DEPTH = 32,
  parameter int TICK_DIV  = 1,
  parameter int COND_BR   = 1
) (
  input  logic                  oscillator,
  input  logic                  reset,
  microprocessor_core_if.master fetch,
  output logic [1:0]            op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  carry,
  output logic                  halted,
  output logic [1:0]            reg_num,
  output logic [DATA_W-1:0]     reg_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     tick_cnt;
  logic              tick;
  logic [PC_W-1:0]   pc;
  logic [7:0]        ir;
  logic [DATA_W-1:0] a, b, result;
  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [1:0]        ir_op, rs, rt, rd;
  logic              is_halt, taken;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] eff;
  logic [AW-1:0]     addr;
  logic [PC_W-1:0]   simm_pc;

  // Power-on contents: ascending values in the lower half, negated offsets in the upper half
  function automatic logic [DATA_W-1:0] mem_init(input int i);
    int v;
    v = (i < MEM_DEPTH / 2) ? i : (MEM_DEPTH / 2 - i);
    return DATA_W'(v);
  endfunction

  assign ir_op   = ir[7:6];
  assign rs      = ir[5:4];
  assign rt      = ir[3:2];
  assign rd      = (ir_op == OP_ADD) ? ir[1:0] : rt;
  assign is_halt = (ir_op == 2'b11) && (ir[3:0] == 4'b1000);
  assign taken   = (COND_BR == 0) || (a == '0);
  assign sum     = {1'b0, a} + {1'b0, b};
  assign eff     = a + {{(DATA_W-2){ir[1]}}, ir[1:0]};
  assign addr    = AW'(eff);
  assign simm_pc = {{(PC_W-4){ir[3]}}, ir[3:0]};

  assign op                        = ir_op;
  assign fetch.instruction_address = pc;

  // Step-rate divider: tick fires once every TICK_DIV oscillator cycles
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CW'(1);
  end
  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  // State register advances only on tick
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset)    state <= S_FETCH;
    else if (tick) state <= state_n;
  end

  // Next-state selection and state-decoded control outputs
  always_comb begin
    state_n         = state;
    fetch.instr_req = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    halted          = 1'b0;
    case (state)
      S_FETCH: begin
        fetch.instr_req = 1'b1;
        if (fetch.instr_valid) state_n = S_DECODE;
      end
      S_DECODE: state_n = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        mem_read  = (ir_op == OP_LOAD);
        mem_write = (ir_op == OP_STORE);
        state_n   = (ir_op == 2'b11) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = (ir_op == OP_ADD) || (ir_op == OP_LOAD);
        state_n   = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_n = S_HALT;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // Architectural state: IR, operand latches, registers, memory, PC, console
  always_ff @(posedge oscillator or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      result   <= '0;
      carry    <= 1'b0;
      reg_num  <= '0;
      reg_data <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= mem_init(i);
    end else if (tick) begin
      case (state)
        S_FETCH: if (fetch.instr_valid) ir <= fetch.instruction;
        S_DECODE: begin
          // operands are frozen here so Rd==rs/rt sees the old value
          a <= regs[rs];
          b <= regs[rt];
        end
        S_EXEC: begin
          case (ir_op)
            OP_ADD: begin
              result <= sum[DATA_W-1:0];
              carry  <= sum[DATA_W];
            end
            OP_LOAD:  result    <= mem[addr];
            OP_STORE: mem[addr] <= b;
            default:  pc <= pc + PC_W'(1) + (taken ? simm_pc : '0);
          endcase
        end
        S_WB: begin
          if ((ir_op == OP_ADD) || (ir_op == OP_LOAD)) begin
            regs[rd] <= result;
            reg_num  <= rd;
            reg_data <= result;
          end
          pc <= pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
